// File: rtl/control_path_gen.sv
// rtl/control_path_gen.sv - control path sequencing off, countdown list, free count and update regimes
`timescale 1ns/1ps
module control_path_gen #(
  parameter int SW          = 4,
  parameter int ELIST_START = 6,
  parameter int ELIST_STEP  = 2,
  parameter int DWELL       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    on,
  input  logic          start,
  input  logic          abort,
  input  logic          y_inc,
  output logic [1:0]    regime,
  output logic          active,
  output logic          done,
  output logic [1:0]    y_select_next,
  output logic [SW-1:0] s_step,
  output logic          s_en,
  output logic          s_add,
  output logic          s_zero,
  output logic          y_en,
  output logic          y_store_x
);

  localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] START_V   = SW'(ELIST_START);
  localparam logic [SW-1:0] STEP_V    = SW'(ELIST_STEP);
  localparam logic [TW-1:0] TIMER_RLD = TW'(DWELL - 1);

  typedef enum logic [3:0] {
    OFF, EL_WAIT, EL_LOAD, EL_HOLD, EL_DEC, EL_DONE, CNT, UPD1, UPD2
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [SW-1:0] rem;
  logic [SW-1:0] dec_step;

  // The last decrement is clipped to what remains so s lands exactly on 0.
  assign dec_step = (rem < STEP_V) ? rem : STEP_V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      timer <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        EL_LOAD: begin
          rem   <= START_V;
          timer <= TIMER_RLD;
        end
        EL_HOLD: if (timer != '0) timer <= timer - TW'(1);
        EL_DEC: begin
          rem   <= rem - dec_step;
          timer <= TIMER_RLD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      OFF: begin
        case (on)
          2'd1:    state_nx = EL_WAIT;
          2'd2:    state_nx = CNT;
          2'd3:    state_nx = UPD1;
          default: state_nx = OFF;
        endcase
      end
      EL_WAIT: begin
        if (abort)         state_nx = OFF;
        else if (start)    state_nx = EL_LOAD;
        else if (on == '0) state_nx = OFF;
      end
      EL_LOAD: state_nx = abort ? OFF : EL_HOLD;
      EL_HOLD: begin
        if (abort)              state_nx = OFF;
        else if (timer == '0)   state_nx = (rem == '0) ? EL_DONE : EL_DEC;
      end
      EL_DEC:  state_nx = abort ? OFF : EL_HOLD;
      EL_DONE: state_nx = OFF;
      CNT:     state_nx = (start && !abort) ? CNT : OFF;
      UPD1:    state_nx = UPD2;
      UPD2:    state_nx = OFF;
      default: state_nx = OFF;
    endcase
  end

  always_comb begin
    regime        = 2'd0;
    active        = 1'b0;
    done          = 1'b0;
    y_select_next = 2'd0;
    s_step        = '0;
    s_en          = 1'b0;
    s_add         = 1'b0;
    s_zero        = 1'b0;
    y_en          = 1'b0;
    y_store_x     = 1'b0;
    case (state)
      EL_WAIT: regime = 2'd1;
      EL_LOAD: begin
        regime = 2'd1;
        active = 1'b1;
        s_en   = 1'b1;
        s_zero = 1'b1;
        s_step = START_V;
      end
      EL_HOLD: begin
        regime = 2'd1;
        active = 1'b1;
      end
      EL_DEC: begin
        regime = 2'd1;
        active = 1'b1;
        s_en   = 1'b1;
        s_step = dec_step;
      end
      EL_DONE: begin
        regime = 2'd1;
        done   = 1'b1;
        s_en   = 1'b1;
        s_zero = 1'b1;
        s_step = START_V;
      end
      CNT: begin
        regime = 2'd2;
        if (start && !abort) begin
          active = 1'b1;
          s_en   = 1'b1;
          s_add  = 1'b1;
          s_step = SW'(1);
          if (y_inc) begin
            y_en          = 1'b1;
            y_select_next = 2'd1;
          end
        end
      end
      UPD1: begin
        regime    = 2'd3;
        y_en      = 1'b1;
        y_store_x = 1'b1;
      end
      UPD2: begin
        regime = 2'd3;
        s_en   = 1'b1;
        s_zero = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_path_gen.sv
// tb/tb_control_path_gen.sv - directed bench for control_path_gen with an s register model
`timescale 1ns/1ps
module tb_control_path_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] on;
  logic       start, abort, y_inc;

  logic [1:0] regime, y_select_next, regime2, y_select_next2;
  logic       active, done, s_en, s_add, s_zero, y_en, y_store_x;
  logic       active2, done2, s_en2, s_add2, s_zero2, y_en2, y_store_x2;
  logic [3:0] s_step, s_step2;
  logic [3:0] s1 = 4'd0;
  logic [3:0] s2 = 4'd0;

  int tests  = 0;
  int failed = 0;
  int cnt_s_en, cnt_y_en;

  always #5 clk = ~clk;

  control_path_gen dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .abort(abort), .y_inc(y_inc),
    .regime(regime), .active(active), .done(done), .y_select_next(y_select_next),
    .s_step(s_step), .s_en(s_en), .s_add(s_add), .s_zero(s_zero),
    .y_en(y_en), .y_store_x(y_store_x)
  );

  control_path_gen #(.SW(4), .ELIST_START(5), .ELIST_STEP(2), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .on(on), .start(start), .abort(abort), .y_inc(y_inc),
    .regime(regime2), .active(active2), .done(done2), .y_select_next(y_select_next2),
    .s_step(s_step2), .s_en(s_en2), .s_add(s_add2), .s_zero(s_zero2),
    .y_en(y_en2), .y_store_x(y_store_x2)
  );

  // Datapath s register driven by the strobes.
  always @(posedge clk) begin
    if (s_en) s1 <= s_zero ? s_step : (s_add ? s1 + s_step : s1 - s_step);
    if (s_en2) s2 <= s_zero2 ? s_step2 : (s_add2 ? s2 + s_step2 : s2 - s_step2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_s1(input int k);
    if (k <= 6)  return 6;
    if (k <= 11) return 4;
    if (k <= 16) return 2;
    if (k <= 21) return 0;
    return 6;
  endfunction

  function automatic logic [31:0] exp_s2(input int k);
    if (k <= 3) return 5;
    if (k <= 5) return 3;
    if (k <= 7) return 1;
    if (k <= 9) return 0;
    return 5;
  endfunction

  function automatic logic [31:0] outs_all;
    return {regime, active, done, y_select_next, s_step, s_en, s_add, s_zero, y_en, y_store_x};
  endfunction

  // Cycle k is the state entered k-1 edges after the edge that samples start.
  task automatic run_elist();
    @(negedge clk); on = 2'd1; start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; on = 2'd0;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      check($sformatf("el_done_c%0d", k), done, (k == 21));
      check($sformatf("el2_done_c%0d", k), done2, (k == 9));
      if (k >= 2) check($sformatf("el_s_c%0d", k), s1, exp_s1(k));
      if (k >= 2 && k <= 12) check($sformatf("el2_s_c%0d", k), s2, exp_s2(k));
      if (k == 1 || k == 3 || k == 5 || k == 7) begin
        check($sformatf("el2_sen_c%0d", k), s_en2, 1);
        check($sformatf("el2_step_c%0d", k), s_step2, (k == 1) ? 5 : (k == 7) ? 1 : 2);
      end
      if (k == 1)  check("el_load_step", s_step, 6);
      if (k == 22) check("el_regime_after", regime, 0);
    end
  endtask

  initial begin
    rst = 1'b1; on = 2'd0; start = 1'b0; abort = 1'b0; y_inc = 1'b0;
    #12;
    check("reset_outs", outs_all(), 0);
    @(negedge clk); rst = 1'b0;
    #1 check("reset_regime", regime, 0);

    // Countdown on both parameter sets
    run_elist();

    // Free count with one wrap
    @(negedge clk); on = 2'd2; start = 1'b1;
    cnt_s_en = 0; cnt_y_en = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); y_inc = (i == 4); #1;
      if (s_en && s_add && s_step == 4'd1 && active) cnt_s_en++;
      if (y_en) cnt_y_en++;
      if (i == 4) check("cnt_ysel", {y_en, y_select_next}, 3'b101);
      if (i == 5) check("cnt_no_yen", y_en, 0);
    end
    check("cnt_s_en_count", cnt_s_en, 10);
    check("cnt_y_en_count", cnt_y_en, 1);
    @(negedge clk); y_inc = 1'b0; start = 1'b0; on = 2'd0; #1;
    check("cnt_stop_strobes", {regime, s_en, active}, {2'd2, 2'b00});
    @(negedge clk); #1;
    check("cnt_off", regime, 0);

    // Update sequence ignores abort
    @(negedge clk); on = 2'd3;
    @(negedge clk); on = 2'd0; abort = 1'b1; #1;
    check("upd1", {regime, y_en, y_store_x, s_en}, {2'd3, 3'b110});
    @(negedge clk); abort = 1'b0; #1;
    check("upd2", {regime, s_en, s_zero, y_en}, {2'd3, 3'b110});
    check("upd2_step", s_step, 0);
    @(negedge clk); #1;
    check("upd_off", regime, 0);
    check("upd_s_zero", s1, 0);

    // Abort in the second hold cycle
    @(negedge clk); on = 2'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; on = 2'd0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1; #1;
    check("abort_hold_active", {regime, active}, 3'b011);
    @(negedge clk); abort = 1'b0; #1;
    check("abort_off", {regime, done}, 3'b000);
    check("abort_s_kept", s1, 6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (i == 19) check("abort_no_done", {done, regime}, 3'b000);
    end

    // Asynchronous reset in a decrement cycle, then a clean countdown
    @(negedge clk); on = 2'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; on = 2'd0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1 check("pre_rst_dec", {s_en, s_zero, active}, 3'b101);
    #1 rst = 1'b1;
    #1 check("async_rst_outs", outs_all(), 0);
    @(negedge clk); rst = 1'b0;
    run_elist();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
